// File: rtl/counter_run_arbiter_if.sv
// ============================================================================
// Module      : counter_run_arbiter_if
// Description : Requester handshake and counter-configuration bundle for
//               counter_run_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_run_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_start;
    logic [NREQ*WIDTH-1:0] req_end;
    logic [NREQ*WIDTH-1:0] req_step;
    logic                  pause;
    logic [NREQ-1:0]       done;
    logic                  done_err;
    logic                  busy;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic [WIDTH-1:0]      cnt_startNum;
    logic [WIDTH-1:0]      cnt_endNum;
    logic [WIDTH-1:0]      cnt_step;
    logic                  cnt_overflow;

    // Arbiter side
    modport slave (
        input  req_valid, req_start, req_end, req_step, pause, cnt_overflow,
        output req_ready, done, done_err, busy, cnt_clr, cnt_en,
               cnt_startNum, cnt_endNum, cnt_step
    );

    // Requester / counter side
    modport master (
        output req_valid, req_start, req_end, req_step, pause, cnt_overflow,
        input  req_ready, done, done_err, busy, cnt_clr, cnt_en,
               cnt_startNum, cnt_endNum, cnt_step
    );
endinterface

`default_nettype wire

// File: rtl/counter_run_arbiter.sv
// ============================================================================
// Module      : counter_run_arbiter
// Description : Round-robin scheduler sharing one counter between NREQ
//               requesters; each grant programs and sequences a full run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_run_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic            clk,
    input  wire logic            rst,
    counter_run_arbiter_if.slave bus
);

    localparam int                 c_IDXW    = $clog2(NREQ);
    localparam int                 c_BEATW   = $clog2(TIMEOUT + 1);
    localparam logic [c_IDXW-1:0]  c_LAST    = c_IDXW'(NREQ - 1);
    localparam logic [c_BEATW-1:0] c_TIMEOUT = c_BEATW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDXW-1:0]   r_rr_ptr;
    logic [c_IDXW-1:0]   r_grant;
    logic [WIDTH-1:0]    r_start;
    logic [WIDTH-1:0]    r_end;
    logic [WIDTH-1:0]    r_step;
    logic [c_BEATW-1:0]  r_beat;
    logic                r_err;

    logic [c_IDXW-1:0]   w_pick;
    logic                w_any;
    logic [NREQ-1:0]     w_ready;
    logic [NREQ-1:0]     w_done;
    logic                w_done_err;
    logic                w_clr;
    logic                w_en;
    logic                w_hs;

    // First valid requester at or after the rotating pointer; scanning the
    // offsets downward lets the smallest offset win.
    always_comb begin : p_pick
        int idx;
        w_pick = r_rr_ptr;
        w_any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx]) begin
                w_pick = c_IDXW'(idx);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_ready     = '0;
        w_done      = '0;
        w_done_err  = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ready     = NREQ'(1) << w_pick;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_clr       = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_en = ~bus.pause & ~bus.cnt_overflow;
                if (bus.cnt_overflow) begin
                    w_state_nxt = S_DONE;
                end else if (!bus.pause && r_beat == c_TIMEOUT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = NREQ'(1) << r_grant;
                w_done_err  = r_err;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hs = (r_state == S_IDLE) && w_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_start  <= '0;
            r_end    <= '0;
            r_step   <= '0;
            r_beat   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_grant <= w_pick;
                r_start <= bus.req_start[int'(w_pick)*WIDTH +: WIDTH];
                r_end   <= bus.req_end[int'(w_pick)*WIDTH +: WIDTH];
                r_step  <= bus.req_step[int'(w_pick)*WIDTH +: WIDTH];
            end
            // Saturate at TIMEOUT so the compare stays valid for any width.
            if (r_state == S_LOAD) begin
                r_beat <= '0;
            end else if (w_en && r_beat != c_TIMEOUT) begin
                r_beat <= r_beat + c_BEATW'(1);
            end
            if (r_state == S_RUN && w_state_nxt == S_DONE) begin
                r_err <= ~bus.cnt_overflow;
            end
            if (r_state == S_DONE) begin
                r_rr_ptr <= (r_grant == c_LAST) ? '0 : r_grant + c_IDXW'(1);
            end
        end
    end

    // Ready is combinational on req_valid, so it is masked while reset is held.
    assign bus.req_ready    = w_ready & {NREQ{~rst}};
    assign bus.done         = w_done;
    assign bus.done_err     = w_done_err;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.cnt_clr      = w_clr;
    assign bus.cnt_en       = w_en;
    assign bus.cnt_startNum = r_start;
    assign bus.cnt_endNum   = r_end;
    assign bus.cnt_step     = r_step;

endmodule

`default_nettype wire

// File: tb/tb_counter_run_arbiter.sv
// ============================================================================
// Module      : tb_counter_run_arbiter
// Description : Self-checking bench for counter_run_arbiter with a behavioural
//               counter attached to each instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_run_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_run_arbiter_if #(.WIDTH(32), .NREQ(4)) ifc ();
    counter_run_arbiter_if #(.WIDTH(32), .NREQ(4)) ifc16 ();

    counter_run_arbiter #(.WIDTH(32), .NREQ(4), .TIMEOUT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    counter_run_arbiter #(.WIDTH(32), .NREQ(4), .TIMEOUT(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (ifc16)
    );

    // Behavioural counters standing in for the shared datapath
    logic [31:0] cnt;
    logic [31:0] cnt16;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            cnt16 <= '0;
        end else begin
            if (ifc.cnt_clr)        cnt <= ifc.cnt_startNum;
            else if (ifc.cnt_en)    cnt <= cnt + ifc.cnt_step;
            if (ifc16.cnt_clr)      cnt16 <= ifc16.cnt_startNum;
            else if (ifc16.cnt_en)  cnt16 <= cnt16 + ifc16.cnt_step;
        end
    end
    assign ifc.cnt_overflow   = (cnt == ifc.cnt_endNum);
    assign ifc16.cnt_overflow = (cnt16 == ifc16.cnt_endNum);

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] st;
        logic [3:0]  rdy;
        logic        clr;
        logic        en;
        logic [31:0] cnt;
        logic [3:0]  dn;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] s, e, st,
                                input logic [3:0] rdy, input logic clr, en,
                                input logic [31:0] c, input logic [3:0] dn,
                                input logic err, busy);
        vec_t v;
        v.valid = valid; v.s = s; v.e = e; v.st = st;
        v.rdy = rdy; v.clr = clr; v.en = en; v.cnt = c;
        v.dn = dn; v.err = err; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int i, input logic [31:0] s, e, st);
        ifc.req_start[i*32 +: 32] = s;
        ifc.req_end[i*32 +: 32]   = e;
        ifc.req_step[i*32 +: 32]  = st;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (ifc.done == 4'd0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_bound"}, (n < limit), 1);
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (ifc.req_ready == 4'd0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_bound"}, (n < limit), 1);
    endtask

    initial begin
        int hs;
        int prev_hs;
        logic [31:0] frozen;
        logic seen;

        ifc.req_valid = '0; ifc.req_start = '0; ifc.req_end = '0; ifc.req_step = '0;
        ifc.pause = 1'b0;
        ifc16.req_valid = '0; ifc16.req_start = '0; ifc16.req_end = '0; ifc16.req_step = '0;
        ifc16.pause = 1'b0;

        // Single run 0..4 step 1 on req0, then a wrapping run on req1
        for (int c = 0; c < 9; c++) begin
            tbl.push_back(mk((c == 0) ? 4'b0001 : 4'b0000, 32'd0, 32'd4, 32'd1,
                             (c == 0) ? 4'b0001 : 4'b0000, (c == 1), (c >= 2 && c <= 5),
                             (c <= 2) ? 32'd0 : ((c <= 6) ? 32'(c - 2) : 32'd4),
                             (c == 7) ? 4'b0001 : 4'b0000, 1'b0, (c >= 1 && c <= 7)));
        end
        tbl.push_back(mk(4'b0010, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0010, 0, 0, 32'd4,          4'b0000, 0, 0));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 1, 0, 32'd4,          4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 1, 32'hFFFF_FFFE, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 1, 32'hFFFF_FFFF, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 1, 32'd0,          4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 0, 32'd1,          4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 0, 32'd1,          4'b0010, 0, 1));
        tbl.push_back(mk(4'b0000, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b0000, 0, 0, 32'd1,          4'b0000, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", ifc.busy, 0);
        check("rst_start", ifc.cnt_startNum, 0);
        check("rst_done", ifc.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[r]) begin
            ifc.req_valid = tbl[r].valid;
            for (int i = 0; i < 4; i++) set_cfg(i, tbl[r].s, tbl[r].e, tbl[r].st);
            @(negedge clk);
            check($sformatf("row%0d.ready", r), ifc.req_ready, tbl[r].rdy);
            check($sformatf("row%0d.clr", r), ifc.cnt_clr, tbl[r].clr);
            check($sformatf("row%0d.en", r), ifc.cnt_en, tbl[r].en);
            check($sformatf("row%0d.cnt", r), cnt, tbl[r].cnt);
            check($sformatf("row%0d.done", r), ifc.done, tbl[r].dn);
            check($sformatf("row%0d.err", r), ifc.done_err, tbl[r].err);
            check($sformatf("row%0d.busy", r), ifc.busy, tbl[r].busy);
            tick();
        end

        // Reset mid-run on req2 (pointer is 2 here), K=10
        set_cfg(2, 32'd0, 32'd10, 32'd1);
        ifc.req_valid = 4'b0100;
        @(negedge clk);
        check("mr_ready", ifc.req_ready, 4'b0100);
        tick();
        ifc.req_valid = 4'b0000;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("mr_busy", ifc.busy, 0);
        check("mr_en", ifc.cnt_en, 0);
        check("mr_clr", ifc.cnt_clr, 0);
        check("mr_cfg", {ifc.cnt_startNum, ifc.cnt_endNum}, 64'd0);
        check("mr_step", ifc.cnt_step, 0);
        check("mr_done", {ifc.done, ifc.done_err, ifc.req_ready}, 0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.done != 4'd0) seen = 1'b1;
        end
        check("mr_no_done", seen, 0);
        tick();
        set_cfg(1, 32'd5, 32'd5, 32'd1);
        set_cfg(3, 32'd5, 32'd5, 32'd1);
        ifc.req_valid = 4'b1010;
        @(negedge clk);
        check("mr_ptr_grant", ifc.req_ready, 4'b0010);
        tick();
        ifc.req_valid = 4'b0000;
        wait_done("mr_run", 20);
        check("mr_run_done", ifc.done, 4'b0010);

        // Round-robin from a fresh pointer, all requesters, K=0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_cfg(i, 32'd7, 32'd7, 32'd3);
        ifc.req_valid = 4'b1111;
        prev_hs = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready($sformatf("rr%0d_ready", g), 20);
            hs = cyc;
            check($sformatf("rr%0d_grant", g), ifc.req_ready, 4'b0001 << (g % 4));
            if (g > 0) check($sformatf("rr%0d_spacing", g), hs - prev_hs, 4);
            prev_hs = hs;
            wait_done($sformatf("rr%0d_done", g), 20);
            check($sformatf("rr%0d_done_oh", g), ifc.done, 4'b0001 << (g % 4));
            check($sformatf("rr%0d_lat", g), cyc - hs, 3);
        end
        tick();
        ifc.req_valid = 4'b0000;

        // Pause for 10 cycles mid-run, K=120
        set_cfg(0, 32'd0, 32'hF000_0000, 32'h0200_0000);
        ifc.req_valid = 4'b0001;
        @(negedge clk);
        check("pz_ready", ifc.req_ready, 4'b0001);
        hs = cyc;
        tick();
        ifc.req_valid = 4'b0000;
        repeat (49) tick();
        ifc.pause = 1'b1;
        @(negedge clk);
        frozen = cnt;
        check("pz_frozen_val", frozen, 32'h6000_0000);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (ifc.cnt_en) seen = 1'b1;
        end
        check("pz_en_low", seen, 0);
        tick();
        ifc.pause = 1'b0;
        check("pz_cnt_held", cnt, 32'h6000_0000);
        wait_done("pz", 300);
        check("pz_lat", cyc - hs, 133);
        check("pz_err", ifc.done_err, 0);

        // Timeout on the TIMEOUT=16 instance: step 0 never reaches end
        tick();
        ifc16.req_start[31:0] = 32'd1;
        ifc16.req_end[31:0]   = 32'd2;
        ifc16.req_step[31:0]  = 32'd0;
        ifc16.req_valid = 4'b0001;
        @(negedge clk);
        check("to_ready", ifc16.req_ready, 4'b0001);
        hs = cyc;
        tick();
        ifc16.req_valid = 4'b0000;
        begin
            int n = 0;
            @(negedge clk);
            while (ifc16.done == 4'd0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("to_bound", (n < 100), 1);
        end
        check("to_lat", cyc - hs, 19);
        check("to_done", ifc16.done, 4'b0001);
        check("to_err", ifc16.done_err, 1);
        check("to_cnt", cnt16, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
